// File: rtl/tetris_pkg.sv
// Shared board constants, controller state encoding and the score helper
// used by the line clear controller.
package tetris_pkg;

    localparam int ROWS = 20;
    localparam int COLS = 10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        FILL = 2'd2,
        DONE = 2'd3
    } lc_state_t;

    typedef struct packed {
        logic [2:0] quo;
        logic [3:0] rem;
    } lc_div10_t;

    // Constant divide-by-ten for small sums (remainder + lines of one update).
    function automatic lc_div10_t div10(input logic [5:0] v);
        lc_div10_t res;
        if (v >= 6'd60) begin
            res.quo = 3'd6;
        end else if (v >= 6'd50) begin
            res.quo = 3'd5;
        end else if (v >= 6'd40) begin
            res.quo = 3'd4;
        end else if (v >= 6'd30) begin
            res.quo = 3'd3;
        end else if (v >= 6'd20) begin
            res.quo = 3'd2;
        end else if (v >= 6'd10) begin
            res.quo = 3'd1;
        end else begin
            res.quo = 3'd0;
        end
        res.rem = 4'(v - ({3'b000, res.quo} * 6'd10));
        return res;
    endfunction

endpackage

// File: rtl/lc_score_counter.sv
// Running line total (saturating) and level, advanced once per ten lines via a
// remainder that carries across sequences.
module lc_score_counter
    import tetris_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        i_add_en,
    input  logic [4:0]  i_add,
    output logic [15:0] o_total,
    output logic [3:0]  o_level
);

    logic [15:0] r_total;
    logic [3:0]  r_level;
    logic [3:0]  r_mod10;
    logic [16:0] w_total_sum;
    logic [5:0]  w_mod_sum;
    lc_div10_t   w_split;
    logic [4:0]  w_level_sum;

    always_comb begin
        w_total_sum = {1'b0, r_total} + {12'h000, i_add};
        w_mod_sum   = {2'b00, r_mod10} + {1'b0, i_add};
        w_split     = div10(w_mod_sum);
        w_level_sum = {1'b0, r_level} + {2'b00, w_split.quo};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_total <= 16'h0000;
            r_level <= 4'd0;
            r_mod10 <= 4'd0;
        end else if (i_add_en) begin
            r_total <= w_total_sum[16] ? 16'hFFFF : w_total_sum[15:0];
            r_level <= (w_level_sum > 5'd15) ? 4'd15 : w_level_sum[3:0];
            r_mod10 <= w_split.rem;
        end else begin
            r_total <= r_total;
            r_level <= r_level;
            r_mod10 <= r_mod10;
        end
    end

    assign o_total = r_total;
    assign o_level = r_level;

endmodule

// File: rtl/line_clear_controller.sv
// Scans the board bottom-up one row per cycle, compacts surviving rows down in
// place, zero-fills the vacated top rows, then reports the score.
module line_clear_controller #(
    parameter int ROWS = tetris_pkg::ROWS,
    parameter int COLS = tetris_pkg::COLS
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    output logic                    busy,
    output logic                    done,
    output logic                    clearing_line,
    output logic [$clog2(ROWS)-1:0] rd_row,
    input  logic [COLS-1:0]         rd_data,
    output logic                    wr_en,
    output logic [$clog2(ROWS)-1:0] wr_row,
    output logic [COLS-1:0]         wr_data,
    output logic [4:0]              lines_cleared,
    output logic [15:0]             total_lines,
    output logic [3:0]              level
);
    import tetris_pkg::*;

    localparam int RW = $clog2(ROWS);
    localparam int NW = $clog2(ROWS + 1);

    lc_state_t     r_state, w_state_next;
    logic [RW-1:0] r_rd_ptr, w_rd_ptr_next;
    logic [RW-1:0] r_wr_ptr, w_wr_ptr_next;
    logic [NW-1:0] r_n, w_n_next;
    logic [4:0]    r_lines_cleared;
    logic [4:0]    w_add;
    logic          w_full;
    logic          w_score_en;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state         <= IDLE;
            r_rd_ptr        <= {RW{1'b0}};
            r_wr_ptr        <= {RW{1'b0}};
            r_n             <= {NW{1'b0}};
            r_lines_cleared <= 5'd0;
        end else begin
            r_state  <= w_state_next;
            r_rd_ptr <= w_rd_ptr_next;
            r_wr_ptr <= w_wr_ptr_next;
            r_n      <= w_n_next;
            if (w_score_en) begin
                r_lines_cleared <= w_add;
            end else begin
                r_lines_cleared <= r_lines_cleared;
            end
        end
    end

    // Writes are combinational so a surviving row moves in the cycle it is read.
    always_comb begin
        w_state_next  = r_state;
        w_rd_ptr_next = r_rd_ptr;
        w_wr_ptr_next = r_wr_ptr;
        w_n_next      = r_n;
        w_score_en    = 1'b0;
        wr_en         = 1'b0;
        wr_row        = {RW{1'b0}};
        wr_data       = {COLS{1'b0}};
        w_full        = &rd_data;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_state_next  = SCAN;
                    w_rd_ptr_next = RW'(ROWS - 1);
                    w_wr_ptr_next = RW'(ROWS - 1);
                    w_n_next      = {NW{1'b0}};
                end else begin
                    w_state_next = IDLE;
                end
            end
            SCAN: begin
                if (w_full) begin
                    w_n_next = r_n + NW'(1);
                end else begin
                    if (r_wr_ptr != r_rd_ptr) begin
                        wr_en   = 1'b1;
                        wr_row  = r_wr_ptr;
                        wr_data = rd_data;
                    end else begin
                        wr_en = 1'b0;
                    end
                    w_wr_ptr_next = r_wr_ptr - RW'(1);
                end
                if (r_rd_ptr == {RW{1'b0}}) begin
                    if (w_n_next != {NW{1'b0}}) begin
                        w_state_next = FILL;
                    end else begin
                        w_state_next = DONE;
                        w_score_en   = 1'b1;
                    end
                end else begin
                    w_rd_ptr_next = r_rd_ptr - RW'(1);
                end
            end
            // After compaction wr_ptr already sits on row n-1, the lowest vacated row.
            FILL: begin
                wr_en  = 1'b1;
                wr_row = r_wr_ptr;
                if (r_wr_ptr == {RW{1'b0}}) begin
                    w_state_next = DONE;
                    w_score_en   = 1'b1;
                end else begin
                    w_wr_ptr_next = r_wr_ptr - RW'(1);
                end
            end
            DONE: begin
                w_state_next = IDLE;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    always_comb begin
        w_add         = 5'(w_n_next);
        busy          = (r_state != IDLE);
        done          = (r_state == DONE);
        clearing_line = busy && ((r_n != {NW{1'b0}}) || ((r_state == SCAN) && w_full));
        rd_row        = r_rd_ptr;
        lines_cleared = r_lines_cleared;
    end

    lc_score_counter u_score (
        .clk      (clk),
        .reset    (reset),
        .i_add_en (w_score_en),
        .i_add    (w_add),
        .o_total  (total_lines),
        .o_level  (level)
    );

endmodule

// File: tb/tb_line_clear_controller.sv
// Directed bench for line_clear_controller: behavioural board memory plus
// hand-computed expectations for latency, writes, board contents and score.
module tb_line_clear_controller;

    localparam int ROWS = 20;
    localparam int COLS = 10;
    localparam int RW   = $clog2(ROWS);
    localparam logic [COLS-1:0] FULL = {COLS{1'b1}};

    logic            clk = 1'b0;
    logic            reset;
    logic            start;
    logic            busy, done, clearing_line, wr_en;
    logic [RW-1:0]   rd_row, wr_row;
    logic [COLS-1:0] rd_data, wr_data;
    logic [4:0]      lines_cleared;
    logic [15:0]     total_lines;
    logic [3:0]      level;

    logic [COLS-1:0] board    [ROWS];
    logic [COLS-1:0] load_img [ROWS];
    logic [COLS-1:0] exp_img  [ROWS];
    logic            load_req;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    line_clear_controller #(.ROWS(ROWS), .COLS(COLS)) dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .busy          (busy),
        .done          (done),
        .clearing_line (clearing_line),
        .rd_row        (rd_row),
        .rd_data       (rd_data),
        .wr_en         (wr_en),
        .wr_row        (wr_row),
        .wr_data       (wr_data),
        .lines_cleared (lines_cleared),
        .total_lines   (total_lines),
        .level         (level)
    );

    assign rd_data = board[rd_row];

    always @(posedge clk) begin
        if (load_req) board <= load_img;
        else if (wr_en) board[wr_row] <= wr_data;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic fill_imgs(input logic [COLS-1:0] ld);
        for (int r = 0; r < ROWS; r++) begin
            load_img[r] = ld;
            exp_img[r]  = {COLS{1'b0}};
        end
    endtask

    task automatic do_load();
        @(negedge clk);
        load_req = 1'b1;
        @(negedge clk);
        load_req = 1'b0;
    endtask

    task automatic check_board(input string tag);
        int bad;
        bad = 0;
        for (int r = 0; r < ROWS; r++) if (board[r] !== exp_img[r]) bad++;
        check(tag, bad, 0);
    endtask

    // One start-to-done sequence with per-cycle observation.
    task automatic run_seq(input string tag, input int exp_n, input int exp_wr, input int repulse_at,
                           input logic [15:0] exp_total, input logic [3:0] exp_level);
        int cyc, cl_err, busy_err, unstable, wr_cnt;
        logic seen_full;
        logic [4:0] lc0;
        logic [15:0] tot0;
        lc0 = lines_cleared;
        tot0 = total_lines;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        cyc = 1; cl_err = 0; busy_err = 0; unstable = 0; wr_cnt = 0; seen_full = 1'b0;
        while (done !== 1'b1 && cyc <= 100) begin
            if (cyc <= ROWS && load_img[ROWS-cyc] == FULL) seen_full = 1'b1;
            if (clearing_line !== ((cyc <= ROWS) ? seen_full : (exp_n != 0))) cl_err++;
            if (busy !== 1'b1) busy_err++;
            if (wr_en === 1'b1) wr_cnt++;
            if (lines_cleared !== lc0 || total_lines !== tot0) unstable++;
            start = (cyc == repulse_at);
            @(posedge clk);
            #1 cyc++;
        end
        start = 1'b0;
        check({tag, " latency"}, cyc, ROWS + exp_n + 1);
        check({tag, " busy_at_done"}, busy, 1);
        check({tag, " wr_en_at_done"}, wr_en, 0);
        check({tag, " clearing_at_done"}, clearing_line, (exp_n != 0));
        check({tag, " lines_cleared"}, lines_cleared, exp_n);
        check({tag, " total_lines"}, total_lines, exp_total);
        check({tag, " level"}, level, exp_level);
        check({tag, " write_count"}, wr_cnt, exp_wr);
        check({tag, " clearing_trace"}, cl_err, 0);
        check({tag, " busy_trace"}, busy_err, 0);
        check({tag, " score_stable"}, unstable, 0);
        @(posedge clk);
        #1;
        check({tag, " done_one_cycle"}, done, 0);
        check({tag, " idle_busy"}, busy, 0);
        check({tag, " lines_held"}, lines_cleared, exp_n);
        check_board({tag, " board"});
    endtask

    initial begin
        int cnt;
        reset = 1'b1; start = 1'b0; load_req = 1'b0;
        fill_imgs({COLS{1'b0}});
        #2;
        check("rst busy", busy, 0);
        check("rst done", done, 0);
        check("rst wr_en", wr_en, 0);
        check("rst rd_row", rd_row, 0);
        check("rst lines", lines_cleared, 0);
        check("rst total", total_lines, 0);
        check("rst level", level, 0);
        @(negedge clk);
        reset = 1'b0;

        // Empty board.
        fill_imgs({COLS{1'b0}});
        do_load();
        run_seq("empty", 0, 0, 0, 16'd0, 4'd0);

        // Row 19 full, row 18 = 001.
        fill_imgs({COLS{1'b0}});
        load_img[19] = FULL; load_img[18] = 10'h001; exp_img[19] = 10'h001;
        do_load();
        run_seq("one", 1, 20, 0, 16'd1, 4'd0);

        // Reset in the middle of FILL.
        fill_imgs({COLS{1'b0}});
        for (int r = 15; r < ROWS; r++) load_img[r] = FULL;
        load_img[14] = 10'h001;
        do_load();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (ROWS + 1) @(posedge clk);
        #1;
        check("midfill busy", busy, 1);
        check("midfill wr_en", wr_en, 1);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("rstfill busy", busy, 0);
        check("rstfill wr_en", wr_en, 0);
        check("rstfill done", done, 0);
        check("rstfill clearing", clearing_line, 0);
        check("rstfill rd_row", rd_row, 0);
        check("rstfill wr_row", wr_row, 0);
        check("rstfill wr_data", wr_data, 0);
        check("rstfill lines", lines_cleared, 0);
        check("rstfill total", total_lines, 0);
        check("rstfill level", level, 0);
        @(negedge clk);
        reset = 1'b0;

        // Clean sequence after reset.
        fill_imgs({COLS{1'b0}});
        load_img[19] = FULL; load_img[18] = 10'h001; exp_img[19] = 10'h001;
        do_load();
        run_seq("after_rst", 1, 20, 0, 16'd1, 4'd0);

        // Seven full rows, start re-pulsed during SCAN.
        fill_imgs({COLS{1'b0}});
        for (int r = 13; r < ROWS; r++) load_img[r] = FULL;
        load_img[12] = 10'h2AA; exp_img[19] = 10'h2AA;
        do_load();
        run_seq("repulse", 7, 20, 5, 16'd8, 4'd0);
        cnt = 0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk);
            #1 if (done === 1'b1 || busy === 1'b1) cnt++;
        end
        check("repulse no_second_seq", cnt, 0);

        // Tetris: rows 16-19 full.
        fill_imgs({COLS{1'b0}});
        for (int r = 16; r < ROWS; r++) load_img[r] = FULL;
        load_img[15] = 10'h3F0; load_img[0] = 10'h001;
        exp_img[19] = 10'h3F0; exp_img[4] = 10'h001;
        do_load();
        run_seq("tetris", 4, 20, 0, 16'd12, 4'd1);

        // Full boards drive level into saturation.
        for (int i = 1; i <= 8; i++) begin
            fill_imgs(FULL);
            do_load();
            run_seq($sformatf("full%0d", i), 20, 20, 0, 16'(12 + 20 * i),
                    ((12 + 20 * i) / 10 > 15) ? 4'd15 : 4'((12 + 20 * i) / 10));
        end

        // Push the running total up to FFFE: 172 + 2108*31 + 14.
        @(negedge clk);
        force dut.u_score.i_add    = 5'd31;
        force dut.u_score.i_add_en = 1'b1;
        repeat (2108) @(posedge clk);
        @(negedge clk);
        force dut.u_score.i_add = 5'd14;
        @(negedge clk);
        release dut.u_score.i_add_en;
        release dut.u_score.i_add;
        #1;
        check("preset total", total_lines, 16'hFFFE);
        check("preset level", level, 4'd15);

        fill_imgs({COLS{1'b0}});
        for (int r = 16; r < ROWS; r++) load_img[r] = FULL;
        do_load();
        run_seq("sat4", 4, 20, 0, 16'hFFFF, 4'd15);

        fill_imgs({COLS{1'b0}});
        load_img[19] = FULL; load_img[18] = 10'h001; exp_img[19] = 10'h001;
        do_load();
        run_seq("sat1", 1, 20, 0, 16'hFFFF, 4'd15);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
